// File: rtl/i2c_arb_pkg.sv
// Shared encodings for the I2C transaction arbiter: engine command opcodes,
// sequencer states and the response-timeout counter width.
package i2c_arb_pkg;

   localparam int unsigned TO_W  = 10;
   localparam int unsigned CMD_W = 3;

   typedef enum logic [CMD_W-1:0] {
      CMD_START     = 3'd0,
      CMD_RESTART   = 3'd1,
      CMD_WRITE     = 3'd2,
      CMD_READ_NACK = 3'd3,
      CMD_STOP      = 3'd4
   } cmd_op_e;

   typedef enum logic [3:0] {
      IDLE,
      S_START,
      DEVW,
      REGA,
      WDATA,
      RSTART,
      DEVR,
      RDATA,
      STOP,
      DONE
   } state_e;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Command/response link between the transaction arbiter and the I2C byte engine.
interface i2c_txn_arbiter_if;
   import i2c_arb_pkg::*;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [CMD_W-1:0] cmd_op;
   logic [7:0]       cmd_data;
   logic             rsp_valid;
   logic [7:0]       rsp_data;
   logic             rsp_nack;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_nack
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_nack
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win_onehot,
   output logic [IW-1:0]   win_idx,
   output logic            win_valid
);

   logic [IW-1:0] cand;

   // Scan NREQ positions starting at ptr; the first set bit wins
   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
      win_valid  = 1'b0;
      cand       = '0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         cand = IW'((32'(ptr) + off) % NREQ);
         if (!win_valid && req[cand]) begin
            win_valid        = 1'b1;
            win_idx          = cand;
            win_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one I2C byte engine between NREQ register-access
// clients; each grant is sequenced into START/address/data/STOP commands.
module i2c_txn_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_rnw,
   input  logic [7*NREQ-1:0] req_dev,
   input  logic [8*NREQ-1:0] req_reg,
   input  logic [8*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [7:0]        rdata,
   output logic              nack,
   output logic              timeout_err,
   output logic              busy,
   i2c_txn_arbiter_if.master eng
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_e            state_q, state_d;
   logic              wait_q, wait_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              rnw_q, rnw_d;
   logic [6:0]        dev_q, dev_d;
   logic [7:0]        rega_q, rega_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rdata_q, rdata_d;
   logic              nack_q, nack_d;
   logic              tout_q, tout_d;

   logic [NREQ-1:0]   win_onehot;
   logic [IW-1:0]     win_idx;
   logic              win_valid;

   logic              sel_rnw;
   logic [6:0]        sel_dev;
   logic [7:0]        sel_reg;
   logic [7:0]        sel_wdata;

   cmd_op_e           op_c;
   logic [7:0]        data_c;
   state_e            nxt_ok;
   logic              is_write;
   logic              cmd_active;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req        (req),
      .ptr        (ptr_q),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .win_valid  (win_valid)
   );

   // Mux the winning requester's transaction fields for latching at grant
   always_comb begin
      sel_rnw   = 1'b0;
      sel_dev   = '0;
      sel_reg   = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_onehot[i]) begin
            sel_rnw   = req_rnw[i];
            sel_dev   = req_dev[7*i +: 7];
            sel_reg   = req_reg[8*i +: 8];
            sel_wdata = req_wdata[8*i +: 8];
         end
      end
   end

   // Per-state engine command and the successor on an error-free response
   always_comb begin
      op_c   = CMD_START;
      data_c = '0;
      nxt_ok = state_q;
      case (state_q)
         S_START: begin op_c = CMD_START;     nxt_ok = DEVW;  end
         DEVW:    begin op_c = CMD_WRITE;     data_c = {dev_q, 1'b0}; nxt_ok = REGA; end
         REGA:    begin op_c = CMD_WRITE;     data_c = rega_q; nxt_ok = rnw_q ? RSTART : WDATA; end
         WDATA:   begin op_c = CMD_WRITE;     data_c = wdata_q; nxt_ok = STOP; end
         RSTART:  begin op_c = CMD_RESTART;   nxt_ok = DEVR;  end
         DEVR:    begin op_c = CMD_WRITE;     data_c = {dev_q, 1'b1}; nxt_ok = RDATA; end
         RDATA:   begin op_c = CMD_READ_NACK; nxt_ok = STOP;  end
         STOP:    begin op_c = CMD_STOP;      nxt_ok = DONE;  end
         default: begin op_c = CMD_START;     nxt_ok = state_q; end
      endcase
   end

   assign is_write   = (op_c == CMD_WRITE);
   assign cmd_active = (state_q != IDLE) && (state_q != DONE);

   // Each command state has an issue phase (wait_q=0) and a response wait
   // phase (wait_q=1); the timeout counter only runs in the wait phase.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      rnw_d   = rnw_q;
      dev_d   = dev_q;
      rega_d  = rega_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      nack_d  = nack_q;
      tout_d  = tout_q;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = S_START;
               wait_d  = 1'b0;
               gnt_d   = win_onehot;
               ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               rnw_d   = sel_rnw;
               dev_d   = sel_dev;
               rega_d  = sel_reg;
               wdata_d = sel_wdata;
               rdata_d = '0;
               nack_d  = 1'b0;
               tout_d  = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: begin
            if (!wait_q) begin
               if (eng.cmd_ready) begin
                  wait_d = 1'b1;
                  cnt_d  = '0;
               end
            end else if (eng.rsp_valid) begin
               wait_d = 1'b0;
               if (is_write && eng.rsp_nack) begin
                  nack_d  = 1'b1;
                  state_d = STOP;
               end else begin
                  state_d = nxt_ok;
               end
               if (state_q == RDATA) rdata_d = eng.rsp_data;
            end else if (cnt_q == TO_W'(TIMEOUT)) begin
               wait_d  = 1'b0;
               tout_d  = 1'b1;
               state_d = (state_q == STOP) ? DONE : STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wait_q  <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         rnw_q   <= 1'b0;
         dev_q   <= '0;
         rega_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         nack_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         rnw_q   <= rnw_d;
         dev_q   <= dev_d;
         rega_q  <= rega_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         nack_q  <= nack_d;
         tout_q  <= tout_d;
      end
   end

   assign eng.cmd_valid = cmd_active && !wait_q;
   assign eng.cmd_op    = op_c;
   assign eng.cmd_data  = data_c;

   assign gnt         = gnt_q;
   assign done        = (state_q == DONE) ? gnt_q : '0;
   assign busy        = (state_q != IDLE);
   assign rdata       = rdata_q;
   assign nack        = nack_q;
   assign timeout_err = tout_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with a reactive byte-engine model.
module tb_i2c_txn_arbiter;
   import i2c_arb_pkg::*;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned TIMEOUT = 1023;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req, req_rnw;
   logic [7*NREQ-1:0] req_dev;
   logic [8*NREQ-1:0] req_reg, req_wdata;
   logic [NREQ-1:0]   gnt, done;
   logic [7:0]        rdata;
   logic              nack, timeout_err, busy;

   i2c_txn_arbiter_if eng ();

   i2c_txn_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .req_rnw     (req_rnw),
      .req_dev     (req_dev),
      .req_reg     (req_reg),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .done        (done),
      .rdata       (rdata),
      .nack        (nack),
      .timeout_err (timeout_err),
      .busy        (busy),
      .eng         (eng)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned done_cnt [NREQ];
   initial begin
      for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) if (done[i] === 1'b1) done_cnt[i]++;
      end
   end

   // engine configuration (written by the main sequence only)
   logic        stall = 1'b0;
   logic        nack_en = 1'b0;
   logic [7:0]  nack_byte = 8'h00;
   logic [7:0]  rd_byte = 8'h00;
   int unsigned hang_idx = 9999;

   // engine state (written by the engine model only)
   logic [10:0] log_cmd [128];
   int unsigned log_cyc [128];
   int unsigned n_log = 0;
   int unsigned stab_err = 0;

   // Engine model: accepts a command, answers on the following cycle unless told to hang
   initial begin : engine
      logic        pend, hold_chk;
      logic [2:0]  pend_op, held_op;
      logic [7:0]  pend_data, held_data;
      int unsigned pend_idx;
      pend = 1'b0; hold_chk = 1'b0; pend_idx = 0;
      pend_op = '0; pend_data = '0; held_op = '0; held_data = '0;
      eng.cmd_ready = 1'b1; eng.rsp_valid = 1'b0; eng.rsp_data = 8'hEE; eng.rsp_nack = 1'b0;
      forever begin
         @(negedge clk);
         eng.rsp_valid = 1'b0;
         eng.rsp_nack  = 1'b0;
         eng.rsp_data  = 8'hEE;
         if (pend) begin
            pend = 1'b0;
            if (pend_idx != hang_idx) begin
               eng.rsp_valid = 1'b1;
               eng.rsp_data  = rd_byte;
               eng.rsp_nack  = nack_en && (pend_op == CMD_WRITE) && (pend_data == nack_byte);
            end
         end
         if (hold_chk && (eng.cmd_valid !== 1'b1 || eng.cmd_op !== held_op || eng.cmd_data !== held_data))
            stab_err++;
         hold_chk = 1'b0;
         eng.cmd_ready = stall ? ~eng.cmd_ready : 1'b1;
         if (eng.cmd_valid === 1'b1) begin
            if (eng.cmd_ready) begin
               if (n_log < 128) begin
                  log_cmd[n_log] = {eng.cmd_op, (eng.cmd_op == CMD_WRITE) ? eng.cmd_data : 8'h00};
                  log_cyc[n_log] = cyc;
               end
               pend      = 1'b1;
               pend_idx  = n_log;
               pend_op   = eng.cmd_op;
               pend_data = eng.cmd_data;
               n_log++;
            end else begin
               hold_chk  = 1'b1;
               held_op   = eng.cmd_op;
               held_data = eng.cmd_data;
            end
         end
      end
   end

   int unsigned checks = 0;
   int unsigned failures = 0;

   logic [7:0] g_rdata, d_rdata;
   logic       d_nack, d_tout;

   // Wait (bounded) for a done pulse, tracking that the grant stays put
   task automatic wait_done(input int unsigned limit, output logic [NREQ-1:0] dn,
                            output logic [NREQ-1:0] g_first, output logic g_stable);
      dn = '0; g_first = '0; g_stable = 1'b1;
      for (int unsigned c = 0; c < limit; c++) begin
         @(negedge clk);
         if (g_first == '0) begin
            g_first = gnt;
            g_rdata = rdata;
         end else if (gnt !== g_first) begin
            g_stable = 1'b0;
         end
         if (done !== '0) begin
            dn = done; d_rdata = rdata; d_nack = nack; d_tout = timeout_err;
            break;
         end
      end
   endtask

   task automatic set_req(input int unsigned i, input logic rnw, input logic [6:0] dv,
                          input logic [7:0] rg, input logic [7:0] wd);
      req_rnw[i]          = rnw;
      req_dev[7*i +: 7]   = dv;
      req_reg[8*i +: 8]   = rg;
      req_wdata[8*i +: 8] = wd;
   endtask

   task automatic test_reset;
      reset = 1'b1; req = '0; req_rnw = '0; req_dev = '0; req_reg = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      checks++; if (gnt !== 4'b0)       begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
      checks++; if (done !== 4'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (eng.cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", eng.cmd_valid); end
      checks++; if ({rdata, nack, timeout_err} !== 10'b0) begin failures++; $display("FAIL reset_status got=%h/%b/%b exp=0", rdata, nack, timeout_err); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_write;
      logic [NREQ-1:0] dn, gf; logic gs; int unsigned base, dc;
      logic [10:0] ex [5];
      ex = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'hA0}, {CMD_WRITE, 8'h10}, {CMD_WRITE, 8'hA5}, {CMD_STOP, 8'h00}};
      base = n_log; dc = done_cnt[0];
      set_req(0, 1'b0, 7'h50, 8'h10, 8'hA5);
      req = 4'b0001;
      wait_done(200, dn, gf, gs);
      req = 4'b0000;
      checks++; if (dn !== 4'b0001) begin failures++; $display("FAIL write_done got=%b exp=0001", dn); end
      checks++; if (gf !== 4'b0001 || gs !== 1'b1) begin failures++; $display("FAIL write_gnt got=%b stable=%b exp=0001 stable=1", gf, gs); end
      checks++; if ({d_nack, d_tout} !== 2'b00) begin failures++; $display("FAIL write_err got=%b%b exp=00", d_nack, d_tout); end
      @(negedge clk);
      checks++; if ({gnt, busy} !== 5'b0) begin failures++; $display("FAIL write_release got=%b/%b exp=0/0", gnt, busy); end
      checks++; if (n_log - base != 5) begin failures++; $display("FAIL write_count got=%0d exp=5", n_log - base); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (log_cmd[base+i] !== ex[i]) begin failures++; $display("FAIL write_seq[%0d] got=%h exp=%h", i, log_cmd[base+i], ex[i]); end
      end
      repeat (3) @(negedge clk);
      checks++; if (done_cnt[0] - dc != 1) begin failures++; $display("FAIL write_done_once got=%0d exp=1", done_cnt[0] - dc); end
   endtask

   task automatic test_stall;
      logic [NREQ-1:0] dn, gf; logic gs; int unsigned base, se;
      logic [10:0] ex [5];
      ex = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'h54}, {CMD_WRITE, 8'h77}, {CMD_WRITE, 8'h3C}, {CMD_STOP, 8'h00}};
      base = n_log; se = stab_err;
      stall = 1'b1;
      set_req(3, 1'b0, 7'h2A, 8'h77, 8'h3C);
      req = 4'b1000;
      wait_done(300, dn, gf, gs);
      req = 4'b0000; stall = 1'b0;
      checks++; if (dn !== 4'b1000) begin failures++; $display("FAIL stall_done got=%b exp=1000", dn); end
      checks++; if (stab_err != se) begin failures++; $display("FAIL stall_hold got=%0d exp=0 unstable cmds", stab_err - se); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (log_cmd[base+i] !== ex[i]) begin failures++; $display("FAIL stall_seq[%0d] got=%h exp=%h", i, log_cmd[base+i], ex[i]); end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_read;
      logic [NREQ-1:0] dn, gf; logic gs; int unsigned base;
      logic [10:0] ex [7];
      ex = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'hA0}, {CMD_WRITE, 8'h20}, {CMD_RESTART, 8'h00},
             {CMD_WRITE, 8'hA1}, {CMD_READ_NACK, 8'h00}, {CMD_STOP, 8'h00}};
      base = n_log; rd_byte = 8'h3C;
      set_req(1, 1'b1, 7'h50, 8'h20, 8'h00);
      req = 4'b0010;
      wait_done(200, dn, gf, gs);
      req = 4'b0000;
      checks++; if (dn !== 4'b0010) begin failures++; $display("FAIL read_done got=%b exp=0010", dn); end
      checks++; if (d_rdata !== 8'h3C) begin failures++; $display("FAIL read_rdata got=%h exp=3c", d_rdata); end
      checks++; if ({d_nack, d_tout} !== 2'b00) begin failures++; $display("FAIL read_err got=%b%b exp=00", d_nack, d_tout); end
      checks++; if (n_log - base != 7) begin failures++; $display("FAIL read_count got=%0d exp=7", n_log - base); end
      for (int i = 0; i < 7; i++) begin
         checks++; if (log_cmd[base+i] !== ex[i]) begin failures++; $display("FAIL read_seq[%0d] got=%h exp=%h", i, log_cmd[base+i], ex[i]); end
      end
      repeat (4) @(negedge clk);
      checks++; if (rdata !== 8'h3C) begin failures++; $display("FAIL read_hold got=%h exp=3c", rdata); end
   endtask

   task automatic test_nack;
      logic [NREQ-1:0] dn, gf; logic gs; int unsigned base;
      logic [10:0] ex [3];
      ex = '{{CMD_START, 8'h00}, {CMD_WRITE, 8'hA0}, {CMD_STOP, 8'h00}};
      base = n_log; nack_en = 1'b1; nack_byte = 8'hA0;
      set_req(0, 1'b0, 7'h50, 8'h11, 8'h22);
      req = 4'b0001;
      wait_done(200, dn, gf, gs);
      req = 4'b0000; nack_en = 1'b0;
      checks++; if (dn !== 4'b0001) begin failures++; $display("FAIL nack_done got=%b exp=0001", dn); end
      checks++; if ({d_nack, d_tout} !== 2'b10) begin failures++; $display("FAIL nack_flags got=%b%b exp=10", d_nack, d_tout); end
      checks++; if (g_rdata !== 8'h00) begin failures++; $display("FAIL nack_rdata_clear got=%h exp=00", g_rdata); end
      checks++; if (n_log - base != 3) begin failures++; $display("FAIL nack_count got=%0d exp=3", n_log - base); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (log_cmd[base+i] !== ex[i]) begin failures++; $display("FAIL nack_seq[%0d] got=%h exp=%h", i, log_cmd[base+i], ex[i]); end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_rr;
      logic [NREQ-1:0] dn, gf; logic gs; int unsigned base;
      logic [NREQ-1:0] ord [5];
      logic [10:0] exdev;
      ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 7'(8'h10 + i), 8'(i), 8'(i));
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         base = n_log;
         wait_done(200, dn, gf, gs);
         checks++; if (dn !== ord[k]) begin failures++; $display("FAIL rr_order[%0d] got=%b exp=%b", k, dn, ord[k]); end
         case (ord[k])
            4'b0001: exdev = {CMD_WRITE, 8'h20};
            4'b0010: exdev = {CMD_WRITE, 8'h22};
            4'b0100: exdev = {CMD_WRITE, 8'h24};
            default: exdev = {CMD_WRITE, 8'h26};
         endcase
         checks++; if (log_cmd[base+1] !== exdev) begin failures++; $display("FAIL rr_dev[%0d] got=%h exp=%h", k, log_cmd[base+1], exdev); end
      end
      req = 4'b0000;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout;
      logic [NREQ-1:0] dn, gf; logic gs; int unsigned base;
      base = n_log; hang_idx = base + 2;
      set_req(0, 1'b0, 7'h50, 8'h10, 8'h5A);
      req = 4'b0001;
      wait_done(3000, dn, gf, gs);
      req = 4'b0000;
      checks++; if (dn !== 4'b0001) begin failures++; $display("FAIL tmo_done got=%b exp=0001", dn); end
      checks++; if ({d_nack, d_tout} !== 2'b01) begin failures++; $display("FAIL tmo_flags got=%b%b exp=01", d_nack, d_tout); end
      checks++; if (n_log - base != 4) begin failures++; $display("FAIL tmo_count got=%0d exp=4", n_log - base); end
      checks++; if (log_cmd[base+3] !== {CMD_STOP, 8'h00}) begin failures++; $display("FAIL tmo_stop got=%h exp=400", log_cmd[base+3]); end
      // REGA accepted, TIMEOUT+1 wait cycles, then one cycle to present STOP
      checks++; if (log_cyc[base+3] - log_cyc[base+2] != TIMEOUT + 2) begin failures++; $display("FAIL tmo_delay got=%0d exp=%0d", log_cyc[base+3] - log_cyc[base+2], TIMEOUT + 2); end
      repeat (2) @(negedge clk);
      base = n_log; hang_idx = base + 4;
      req = 4'b0001;
      wait_done(3000, dn, gf, gs);
      req = 4'b0000; hang_idx = 9999;
      checks++; if (dn !== 4'b0001) begin failures++; $display("FAIL tmo_stop_done got=%b exp=0001", dn); end
      checks++; if ({d_nack, d_tout} !== 2'b01) begin failures++; $display("FAIL tmo_stop_flags got=%b%b exp=01", d_nack, d_tout); end
      checks++; if (n_log - base != 5) begin failures++; $display("FAIL tmo_stop_count got=%0d exp=5", n_log - base); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic [NREQ-1:0] dn, gf; logic gs; int unsigned base, snap, c;
      base = n_log; hang_idx = base + 5;
      set_req(1, 1'b1, 7'h33, 8'h44, 8'h00);
      req = 4'b0010;
      c = 0;
      while (n_log < base + 6 && c < 200) begin @(negedge clk); c++; end
      checks++; if (n_log < base + 6) begin failures++; $display("FAIL rst_reach_rdata got=%0d exp=6 cmds", n_log - base); end
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
      reset = 1'b1;
      #1;
      checks++; if ({gnt, eng.cmd_valid, busy, done} !== 10'b0) begin failures++; $display("FAIL rst_async got=gnt%b v%b b%b d%b exp=0", gnt, eng.cmd_valid, busy, done); end
      req = 4'b0000;
      @(negedge clk); reset = 1'b0; hang_idx = 9999;
      snap = n_log;
      repeat (4) @(negedge clk);
      checks++; if (n_log != snap) begin failures++; $display("FAIL rst_no_stop got=%0d exp=0 cmds", n_log - snap); end
      set_req(2, 1'b0, 7'h12, 8'h34, 8'h56);
      req = 4'b0100;
      wait_done(200, dn, gf, gs);
      req = 4'b0000;
      checks++; if (gf !== 4'b0100) begin failures++; $display("FAIL rst_first_gnt got=%b exp=0100", gf); end
      checks++; if (dn !== 4'b0100) begin failures++; $display("FAIL rst_done got=%b exp=0100", dn); end
      checks++; if (log_cmd[snap] !== {CMD_START, 8'h00}) begin failures++; $display("FAIL rst_first_cmd got=%h exp=000", log_cmd[snap]); end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset;
      test_write;
      test_stall;
      test_read;
      test_nack;
      test_rr;
      test_timeout;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one byte-level I2C master engine between NREQ requesters; round-robin arbitration per register transaction.
- Sequences each granted transaction into engine commands: START, device address, register address, then data write, or repeated START and data read, then STOP.
- Sits between on-chip clients (sensor pollers, config loaders) and the I2C byte engine that drives scl/sda.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1023, max clk cycles waiting for a single engine response before abort (10-bit counter)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester transaction request, held high until its done pulse
- req_rnw  in  NREQ  1 = register read, 0 = register write
- req_dev  in  7*NREQ  7-bit device address, slice i = [7i+6:7i]
- req_reg  in  8*NREQ  register address
- req_wdata  in  8*NREQ  write data
- gnt  out  NREQ  one-hot grant, high for the whole transaction
- done  out  NREQ  one-cycle completion pulse to the granted requester
- rdata  out  8  read data, valid with done
- nack  out  1  slave NACK seen, valid with done
- timeout_err  out  1  engine timeout, valid with done
- busy  out  1  transaction in progress
- cmd_valid  out  1  command to engine
- cmd_ready  in  1  engine accepts command
- cmd_op  out  3  0 START, 1 RESTART, 2 WRITE, 3 READ_NACK, 4 STOP
- cmd_data  out  8  byte for WRITE
- rsp_valid  in  1  engine finished the last accepted command
- rsp_data  in  8  byte received on READ_NACK
- rsp_nack  in  1  slave NACKed a WRITE byte

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0. Reset mid-transaction aborts with no STOP and no done; the engine is reset separately.
- Arbitration (IDLE): req != 0 -> pick first set bit at or after pointer, wrapping; latch rnw/dev/reg/wdata of winner; assert gnt next cycle; pointer <= winner+1 mod NREQ. Later changes to req inputs are ignored until done.
- Command handshake: hold cmd_valid, cmd_op, cmd_data stable until cmd_valid && cmd_ready; then cmd_valid=0, wait for rsp_valid. The counter starts at acceptance and counts to TIMEOUT. rsp_valid in the same cycle as counter==TIMEOUT counts as a response, not a timeout.
- States: IDLE -> S_START -> DEVW (dev,0) -> REGA (reg) -> write: WDATA (wdata) -> STOP; read: RSTART -> DEVR (dev,1) -> RDATA (READ_NACK) -> STOP -> DONE -> IDLE.
- rsp_nack on any WRITE: set nack, go straight to STOP.
- Timeout in any wait: set timeout_err, go to STOP. A timeout during STOP itself goes to DONE.
- RDATA response: latch rsp_data into rdata.
- DONE (1 cycle): done[winner]=1, gnt=0, busy=0 next cycle. rdata, nack and timeout_err hold until the next grant, then clear.
- Minimum latency, engine ready and responding the next cycle: write 5 commands and read 7 commands, at 2 cycles each, plus 3 cycles arb/done.
- busy = state != IDLE. A requester may re-request the cycle after its done pulse; it is granted only after the pointer cycles past the other pending requesters.
- Error-free transaction ends with nack=0 and timeout_err=0. rdata is undefined-held (previous value) for writes.

Decomposition:
- Package i2c_arb_pkg: cmd_op encodings (CMD_START..CMD_STOP), state enum, TIMEOUT counter width constant.
- Sub-module rr_arbiter (NREQ): req vector and pointer in, one-hot winner and index out, purely combinational. The FSM, datapath latches and counter stay in i2c_txn_arbiter.

Test Plan:
- Req0 write dev 0x50 reg 0x10 data 0xA5, ideal engine -> cmd_data seq START, 0xA0, 0x10, 0xA5, STOP; done[0] once; nack=0; gnt[0] high throughout.
- Req1 read dev 0x50 reg 0x20, engine returns 0x3C -> seq START, 0xA0, 0x20, RESTART, 0xA1, READ_NACK, STOP; rdata=0x3C with done[1].
- Engine rsp_nack on device byte 0xA0 -> next op STOP, skips REGA; done with nack=1, rdata unchanged.
- req=4'b1111 held, re-asserted after each done -> grant order 0,1,2,3,0; no requester served twice in a row while others pend.
- Engine never asserts rsp_valid after REGA accept -> after TIMEOUT+1 cycles STOP issued, done with timeout_err=1.
- Reset asserted mid-RDATA wait -> same-cycle gnt=0, cmd_valid=0, busy=0; post-reset req2 alone is granted first.
